// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - init sweep plus core/debug arbitration of the register file write and RS2 ports
module regfile_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_REGS     = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_wr_valid,
    input  logic [ADDR_WIDTH-1:0] core_wr_addr,
    input  logic [DATA_WIDTH-1:0] core_wr_data,
    output logic                  core_wr_ready,
    input  logic [ADDR_WIDTH-1:0] core_rs2_addr,
    output logic                  core_stall,
    input  logic                  dbg_req_valid,
    input  logic                  dbg_req_write,
    input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
    input  logic [DATA_WIDTH-1:0] dbg_req_wdata,
    output logic                  dbg_req_ready,
    output logic                  dbg_rsp_valid,
    output logic [DATA_WIDTH-1:0] dbg_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] rf_write_address,
    output logic [DATA_WIDTH-1:0] rf_data_input,
    output logic                  rf_enable,
    output logic [ADDR_WIDTH-1:0] rf_read_address_RS2,
    input  logic [DATA_WIDTH-1:0] rf_data_output_RS2,
    output logic                  init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] LAST_REG   = ADDR_WIDTH'(NUM_REGS - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  init_done_q, init_done_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                  grant_dbg;
    logic                  grant_core;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  core_ready_c;
    logic                  dbg_ready_c;
    logic                  stall_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            starve_q    <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        starve_d     = starve_q;
        init_done_d  = init_done_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        grant_dbg    = 1'b0;
        grant_core   = 1'b0;
        wr_req       = 1'b0;
        wr_addr      = core_wr_addr;
        wr_data      = core_wr_data;
        rd_addr      = core_rs2_addr;
        core_ready_c = 1'b0;
        dbg_ready_c  = 1'b0;
        stall_c      = 1'b1;

        case (state_q)
            ST_INIT: begin
                wr_req  = 1'b1;
                wr_addr = cnt_q;
                wr_data = '0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_REG) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            ST_RUN: begin
                // Debug only beats a concurrent core write once it has waited out the starve limit.
                grant_dbg  = dbg_req_valid && (!core_wr_valid || (starve_q == STARVE_MAX));
                grant_core = core_wr_valid && !grant_dbg;
                stall_c    = 1'b0;

                if (grant_dbg) begin
                    dbg_ready_c = 1'b1;
                    stall_c     = 1'b1;
                    wr_addr     = dbg_req_addr;
                    wr_data     = dbg_req_wdata;
                    rsp_valid_d = 1'b1;
                    if (dbg_req_write) begin
                        wr_req      = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        rd_addr     = dbg_req_addr;
                        rsp_rdata_d = rf_data_output_RS2;
                    end
                end else if (grant_core) begin
                    core_ready_c = 1'b1;
                    wr_req       = 1'b1;
                end

                if (!dbg_req_valid || grant_dbg) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_MAX) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // x0 stays hardwired to zero once the sweep is over; the handshake still completes.
    assign rf_enable           = rst_n && wr_req && ((state_q == ST_INIT) || (wr_addr != '0));
    assign rf_write_address    = wr_addr;
    assign rf_data_input       = wr_data;
    assign rf_read_address_RS2 = rd_addr;
    assign core_wr_ready       = rst_n && core_ready_c;
    assign dbg_req_ready       = rst_n && dbg_ready_c;
    assign core_stall          = !rst_n || stall_c;
    assign init_done           = init_done_q;
    assign dbg_rsp_valid       = rsp_valid_q;
    assign dbg_rsp_rdata       = rsp_rdata_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - self-checking bench for regfile_port_arbiter
module tb_regfile_port_arbiter;

    localparam int NREG  = 32;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_wr_valid = 1'b0;
    logic [4:0]  core_wr_addr = '0;
    logic [31:0] core_wr_data = '0;
    logic        core_wr_ready;
    logic [4:0]  core_rs2_addr = 5'd3;
    logic        core_stall;
    logic        dbg_req_valid = 1'b0;
    logic        dbg_req_write = 1'b0;
    logic [4:0]  dbg_req_addr = '0;
    logic [31:0] dbg_req_wdata = '0;
    logic        dbg_req_ready;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rsp_rdata;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_data_input;
    logic        rf_enable;
    logic [4:0]  rf_read_address_RS2;
    logic [31:0] rf_data_output_RS2;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    regfile_port_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(NREG), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_wr_valid(core_wr_valid), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_wr_ready(core_wr_ready), .core_rs2_addr(core_rs2_addr), .core_stall(core_stall),
        .dbg_req_valid(dbg_req_valid), .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
        .dbg_req_wdata(dbg_req_wdata), .dbg_req_ready(dbg_req_ready),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata),
        .rf_write_address(rf_write_address), .rf_data_input(rf_data_input), .rf_enable(rf_enable),
        .rf_read_address_RS2(rf_read_address_RS2), .rf_data_output_RS2(rf_data_output_RS2),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Register file stand-in, preloaded with garbage the sweep must clear.
    logic [31:0] rf_mem [NREG] = '{default: 32'hDEAD_BEEF};
    always @(posedge clk) if (rf_enable) rf_mem[rf_write_address] <= rf_data_input;
    assign rf_data_output_RS2 = rf_mem[rf_read_address_RS2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: sweep position, starvation count, pending response and expected memory.
    bit          m_init = 1'b1, m_done = 1'b0, m_rv = 1'b0;
    int          m_cnt = 0, m_starve = 0;
    logic [31:0] m_rd = '0;
    logic [31:0] m_mem [NREG] = '{default: 32'hDEAD_BEEF};
    bit          n_init = 1'b1, n_done = 1'b0, n_rv = 1'b0, n_we = 1'b0;
    int          n_cnt = 0, n_starve = 0;
    logic [31:0] n_rd = '0, n_wd = '0;
    logic [4:0]  n_wa = '0;
    bit          gd, gc, exp_en;
    logic [4:0]  exp_wa, exp_ra;
    logic [31:0] exp_wd;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rf_enable", 32'(rf_enable), 32'd0);
            chk("rst_core_ready", 32'(core_wr_ready), 32'd0);
            chk("rst_dbg_ready", 32'(dbg_req_ready), 32'd0);
            chk("rst_core_stall", 32'(core_stall), 32'd1);
            chk("rst_init_done", 32'(init_done), 32'd0);
            chk("rst_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
            chk("rst_rsp_rdata", dbg_rsp_rdata, 32'd0);
            n_init = 1; n_done = 0; n_cnt = 0; n_starve = 0; n_rv = 0; n_rd = '0; n_we = 0;
        end else begin
            chk("init_done", 32'(init_done), 32'(m_done));
            chk("rsp_valid", 32'(dbg_rsp_valid), 32'(m_rv));
            chk("rsp_rdata", dbg_rsp_rdata, m_rd);
            if (m_init) begin
                chk("sweep_en", 32'(rf_enable), 32'd1);
                chk("sweep_addr", 32'(rf_write_address), 32'(m_cnt));
                chk("sweep_data", rf_data_input, 32'd0);
                chk("sweep_stall", 32'(core_stall), 32'd1);
                chk("sweep_core_ready", 32'(core_wr_ready), 32'd0);
                chk("sweep_dbg_ready", 32'(dbg_req_ready), 32'd0);
                chk("sweep_rs2", 32'(rf_read_address_RS2), 32'(core_rs2_addr));
                n_we = 1; n_wa = 5'(m_cnt); n_wd = '0;
                n_done = (m_cnt == NREG - 1);
                n_init = !n_done;
                n_cnt = n_done ? 0 : m_cnt + 1;
                n_starve = 0; n_rv = 0; n_rd = m_rd;
            end else begin
                gd = dbg_req_valid && (!core_wr_valid || m_starve == LIMIT);
                gc = core_wr_valid && !gd;
                exp_en = 0; exp_wa = core_wr_addr; exp_wd = core_wr_data; exp_ra = core_rs2_addr;
                if (gd && dbg_req_write) begin
                    exp_en = (dbg_req_addr != 0); exp_wa = dbg_req_addr; exp_wd = dbg_req_wdata;
                end else if (gd) begin
                    exp_ra = dbg_req_addr;
                end else if (gc) begin
                    exp_en = (core_wr_addr != 0);
                end
                chk("run_en", 32'(rf_enable), 32'(exp_en));
                if ((gd && dbg_req_write) || gc) begin
                    chk("run_waddr", 32'(rf_write_address), 32'(exp_wa));
                    chk("run_wdata", rf_data_input, exp_wd);
                end
                chk("run_rs2", 32'(rf_read_address_RS2), 32'(exp_ra));
                chk("run_core_ready", 32'(core_wr_ready), 32'(gc));
                chk("run_dbg_ready", 32'(dbg_req_ready), 32'(gd));
                chk("run_stall", 32'(core_stall), 32'(gd));
                n_we = exp_en; n_wa = exp_wa; n_wd = exp_wd;
                n_rv = gd;
                n_rd = gd ? (dbg_req_write ? 32'd0 : m_mem[dbg_req_addr]) : m_rd;
                n_starve = (!dbg_req_valid || gd) ? 0 : ((m_starve < LIMIT) ? m_starve + 1 : LIMIT);
                n_init = 0; n_done = 1; n_cnt = 0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_init <= 1; m_done <= 0; m_cnt <= 0; m_starve <= 0; m_rv <= 0; m_rd <= '0;
        end else begin
            m_init <= n_init; m_done <= n_done; m_cnt <= n_cnt; m_starve <= n_starve;
            m_rv <= n_rv; m_rd <= n_rd;
            if (n_we) m_mem[n_wa] <= n_wd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sweep(input string tag);
        int n = 0;
        #1;
        while (!init_done && n < 40) begin
            chk({tag, "_addr"}, 32'(rf_write_address), 32'(n));
            chk({tag, "_en"}, 32'(rf_enable), 32'd1);
            n++;
            tick();
            #1;
        end
        chk({tag, "_len"}, 32'(n), 32'd32);
    endtask

    initial begin
        repeat (3) tick();
        chk("lit_rst_stall", 32'(core_stall), 32'd1);
        chk("lit_rst_en", 32'(rf_enable), 32'd0);

        // Core tries to write during the sweep and must be held off.
        core_wr_valid = 1; core_wr_addr = 5'd7; core_wr_data = 32'h1234_5678;
        rst_n = 1;
        do_sweep("sweep1");
        chk("lit_core_after_sweep", 32'(core_wr_ready), 32'd1);
        tick();
        core_wr_valid = 0;

        core_wr_valid = 1; core_wr_addr = 5'd5; core_wr_data = 32'hFFFA_BCDE;
        #1 chk("lit_core5_ready", 32'(core_wr_ready), 32'd1);
        tick();
        core_wr_valid = 0;
        dbg_req_valid = 1; dbg_req_write = 0; dbg_req_addr = 5'd5;
        #1 chk("lit_dbg_rd_ready", 32'(dbg_req_ready), 32'd1);
        chk("lit_dbg_rd_stall", 32'(core_stall), 32'd1);
        tick();
        dbg_req_valid = 0;
        #1 chk("lit_rsp5_valid", 32'(dbg_rsp_valid), 32'd1);
        chk("lit_rsp5_data", dbg_rsp_rdata, 32'hFFFA_BCDE);
        tick();
        #1 chk("lit_rsp_pulse", 32'(dbg_rsp_valid), 32'd0);

        // Both requesters held high: four core grants, one debug grant, core resumes.
        core_wr_valid = 1; core_wr_addr = 5'd10; core_wr_data = 32'h0A0A_0A0A;
        dbg_req_valid = 1; dbg_req_write = 0; dbg_req_addr = 5'd5;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("lit_starve_core%0d", i), 32'(core_wr_ready), 32'(i != 4));
            chk($sformatf("lit_starve_dbg%0d", i), 32'(dbg_req_ready), 32'(i == 4));
            tick();
            if (i == 4) dbg_req_valid = 0;
        end
        core_wr_valid = 0;

        dbg_req_valid = 1; dbg_req_write = 1; dbg_req_addr = 5'd9; dbg_req_wdata = 32'hABEF_FFCD;
        #1 chk("lit_dbg9_ready", 32'(dbg_req_ready), 32'd1);
        chk("lit_dbg9_en", 32'(rf_enable), 32'd1);
        tick();
        dbg_req_valid = 0;
        #1 chk("lit_dbg9_rsp", 32'(dbg_rsp_valid), 32'd1);
        chk("lit_dbg9_rdata", dbg_rsp_rdata, 32'd0);
        tick();

        dbg_req_valid = 1; dbg_req_write = 1; dbg_req_addr = 5'd0; dbg_req_wdata = 32'hABCD_EFFF;
        #1 chk("lit_x0_ready", 32'(dbg_req_ready), 32'd1);
        chk("lit_x0_en", 32'(rf_enable), 32'd0);
        tick();
        dbg_req_write = 0;
        #1 chk("lit_x0_wrsp", 32'(dbg_rsp_valid), 32'd1);
        chk("lit_x0_rd_ready", 32'(dbg_req_ready), 32'd1);
        tick();
        dbg_req_valid = 0;
        #1 chk("lit_x0_rrsp", 32'(dbg_rsp_valid), 32'd1);
        chk("lit_x0_rdata", dbg_rsp_rdata, 32'd0);
        tick();

        dbg_req_valid = 1; dbg_req_write = 0; dbg_req_addr = 5'd9;
        tick();
        dbg_req_valid = 0;
        #1 chk("lit_rd9_rdata", dbg_rsp_rdata, 32'hABEF_FFCD);
        tick();

        // Reset again, then interrupt the sweep at counter 12.
        rst_n = 0;
        #1 chk("lit_arst_done", 32'(init_done), 32'd0);
        chk("lit_arst_rdata", dbg_rsp_rdata, 32'd0);
        tick();
        rst_n = 1;
        repeat (12) tick();
        #1 chk("lit_mid_addr", 32'(rf_write_address), 32'd12);
        rst_n = 0;
        #1 chk("lit_mid_en", 32'(rf_enable), 32'd0);
        chk("lit_mid_stall", 32'(core_stall), 32'd1);
        tick();
        tick();
        rst_n = 1;
        do_sweep("sweep2");
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
Sequences and shares the 32x32 register file between the core writeback path and a debug access port.
- After reset it runs an init sweep that writes zero to every register.
- It then arbitrates the single write port and the RS2 read port between the core and debug, with starvation protection for debug.
- It sits between the core datapath/debug module and the RegisterFile instance, driving its write_address/data_input/enable/read_address_RS2 inputs.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register address width
NUM_REGS, 32, registers cleared by init sweep (addresses 0..NUM_REGS-1)
STARVE_LIMIT, 4, consecutive denied debug cycles before debug preempts core

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
core_wr_valid  in  1  core writeback request
core_wr_addr  in  ADDR_WIDTH  core writeback register
core_wr_data  in  DATA_WIDTH  core writeback data
core_wr_ready  out  1  core write accepted this cycle
core_rs2_addr  in  ADDR_WIDTH  core RS2 read address
core_stall  out  1  core must hold PC/state this cycle
dbg_req_valid  in  1  debug request
dbg_req_write  in  1  1 = write, 0 = read
dbg_req_addr  in  ADDR_WIDTH  debug register address
dbg_req_wdata  in  DATA_WIDTH  debug write data
dbg_req_ready  out  1  debug request granted this cycle
dbg_rsp_valid  out  1  debug response, one-cycle pulse
dbg_rsp_rdata  out  DATA_WIDTH  debug read data (0 for writes)
rf_write_address  out  ADDR_WIDTH  to RegisterFile write_address
rf_data_input  out  DATA_WIDTH  to RegisterFile data_input
rf_enable  out  1  to RegisterFile enable
rf_read_address_RS2  out  ADDR_WIDTH  to RegisterFile read_address_RS2
rf_data_output_RS2  in  DATA_WIDTH  from RegisterFile data_output_RS2
init_done  out  1  init sweep complete

Behaviour:
- Reset (rst_n low, asynchronous, any state including mid-sweep): state=INIT, sweep counter=0, starve counter=0, init_done=0, dbg_rsp_valid=0, dbg_rsp_rdata=0. A pending debug response is dropped.
- Combinational outputs while reset is asserted: rf_enable=0, core_wr_ready=0, dbg_req_ready=0, core_stall=1.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle: rf_enable=1, rf_write_address=counter, rf_data_input=0; counter increments.
  - When counter reaches NUM_REGS-1 and that write completes, move to RUN and set init_done=1 (registered). The sweep therefore takes exactly NUM_REGS cycles after rst_n rises.
  - Throughout INIT: core_stall=1, core_wr_ready=0, dbg_req_ready=0.
- RUN grant rule (combinational, same cycle):
  - grant_dbg = dbg_req_valid && (!core_wr_valid || starve==STARVE_LIMIT).
  - grant_core = core_wr_valid && !grant_dbg.
- Core grant: core_wr_ready=1; rf_write_address/rf_data_input driven from core_wr_addr/core_wr_data; rf_read_address_RS2=core_rs2_addr; core_stall=0.
- Debug grant:
  - dbg_req_ready=1, core_stall=1, core_wr_ready=0.
  - Write: rf_enable=1 with the debug addr/data.
  - Read: rf_read_address_RS2=dbg_req_addr and rf_enable=0.
- No grant: rf_enable=0; rf_read_address_RS2=core_rs2_addr; core_stall=0.
- x0 protection: any granted write with address 0 in RUN forces rf_enable=0. The handshake still completes (ready=1, response still issued). INIT is the only phase that writes address 0.
- Debug response: the cycle after a debug grant, dbg_rsp_valid=1 for exactly one cycle. dbg_rsp_rdata = rf_data_output_RS2 sampled at the grant edge for reads, 0 for writes. Otherwise dbg_rsp_valid=0 and rdata holds its last value.
- Starve counter:
  - Increments on dbg_req_valid && !grant_dbg, saturating at STARVE_LIMIT.
  - Clears on a debug grant or when dbg_req_valid=0.
- Simultaneous requests: core wins until debug has been denied STARVE_LIMIT consecutive cycles; debug then wins exactly one cycle and the counter clears.
- Requesters must hold valid and payload stable until ready. Back-to-back debug requests may be granted on consecutive cycles.

Test Plan:
- Release rst_n, pre-load garbage via the core path is blocked -> rf_enable=1 for 32 cycles with addresses 0..31 and data 0; init_done rises on cycle 32; core_stall=1 throughout.
- RUN, core write addr 5 data 0xFFFABCDE, then debug read addr 5 -> core_wr_ready=1; next cycle dbg_req_ready=1, core_stall=1; following cycle dbg_rsp_valid=1, rdata=0xFFFABCDE.
- core_wr_valid held high and dbg_req_valid held high -> core granted 4 cycles, debug granted on the 5th with core_wr_ready=0 that cycle, then the core resumes.
- Debug write addr 0 data 0xABCDEFFF, then debug read addr 0 -> rf_enable=0 on the write, handshake and response still occur, read returns 0x00000000.
- Assert rst_n low mid-sweep at counter=12 -> outputs return to reset values immediately; on release the sweep restarts at address 0 and takes the full 32 cycles.
- Debug write addr 9 data 0xABEFFFCD with no core traffic -> granted the same cycle, rf_enable=1, dbg_rsp_valid pulses next cycle with rdata=0.
